div_iter_unit: RTL
==================

Name: div_iter_unit

Overview:
- Multi-cycle iterative radix-2 divider for the execute stage. Executes MIPS DIV/DIVU.
- Drives the execute-stage divide stall into the hazard unit, which holds F/D/E while it is high.
- Delivers a 64-bit {remainder, quotient} result for the HI/LO write.
- Aborts on exception flush from the hazard unit.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start_i  input  1  DIV/DIVU present in E stage; held high while stalled.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- dividend_i  input  WIDTH  rs value, forwarded; sampled only on acceptance.
- divisor_i  input  WIDTH  rt value, forwarded; sampled only on acceptance.
- annul_i  input  1  flush of E stage (exception); cancels operation.
- div_stall_o  output  1  to hazard unit as div_stallE.
- ready_o  output  1  one-cycle pulse: result_o valid for the HI/LO write.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, result_o=0, ready_o=0.
  - div_stall_o=0 while rst is high.
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0 accepts the operands. Accepted operands are latched internally; later input changes are ignored.
  - If divisor_i==0, next state is ZERO.
  - Otherwise, next state is RUN with counter=0.
  - Signed mode converts operands to magnitudes. Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
- RUN:
  - One restoring step per cycle: shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor magnitude from the upper WIDTH+1 bits. If the result is non-negative, keep it and set the quotient LSB to 1; else restore and set the LSB to 0.
  - counter increments each cycle. After the step at counter==WIDTH-1, next state is DONE.
- ZERO: next state is DONE; result is forced to 0 (quotient=0, remainder=0). Architecturally undefined; fixed here for determinism.
- DONE:
  - result_o is registered with signs applied. Quotient is negated if its sign bit is set; remainder is negated if the dividend was negative.
  - ready_o=1 for exactly this cycle. Next state is IDLE unconditionally.
  - A new start_i seen in IDLE the following cycle is a new, back-to-back divide.
- div_stall_o (combinational):
  - Equals (IDLE & start_i) | ZERO | RUN, masked by ~annul_i.
  - Deasserted in DONE so the instruction advances on the DONE edge.
- Latency, non-zero divisor:
  - Acceptance in cycle 0; RUN in cycles 1..WIDTH; DONE in cycle WIDTH+1.
  - div_stall_o is high for WIDTH+1 cycles (33 at default).
- Latency, divide by zero: stall in cycles 0..1; DONE in cycle 2.
- annul_i:
  - Any state goes to IDLE on the next edge. ready_o is not pulsed and result_o keeps its previous value.
  - annul_i in DONE suppresses ready_o in that cycle.
  - annul_i has priority over start_i.
- result_o holds its value until the next DONE; it does not change during RUN.
- Boundary: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (magnitude wrap). No overflow flag.
- Arithmetic: the partial remainder is WIDTH+1 bits wide. Magnitudes are unsigned WIDTH bits, so 0x80000000 is representable.
- Reset mid-RUN: immediate async return to IDLE; all outputs return to their reset values.

Test Plan:
- Unsigned 100/7 (signed_i=0):
  - div_stall_o high for 33 cycles.
  - ready_o pulse in cycle 33, result_o=0x00000002_0000000E.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 7/-2 (0x00000007 / 0xFFFFFFFE): result_o = {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: result_o = {0x00000000, 0x80000000}.
- Divide by zero 5/0:
  - div_stall_o high in cycles 0..1.
  - ready_o in cycle 2, result_o=0.
- annul_i at cycle 10 of RUN:
  - Next cycle IDLE with div_stall_o=0.
  - No ready_o; result_o unchanged from the prior value.
  - A fresh start_i then completes normally.
- Back-to-back: start_i held through DONE with new operands 9/3. A second 33-cycle stall follows, then ready_o with {0, 3}.
- rst pulse during RUN: outputs go to 0 asynchronously; no ready_o afterwards.

Source files
------------

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle radix-2 restoring divider for the execute stage (MIPS DIV/DIVU).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      divide present in E stage (held high while stalled)
//   signed_i     1 = DIV (signed), 0 = DIVU
//   dividend_i   rs operand, sampled only on acceptance
//   divisor_i    rt operand, sampled only on acceptance
//   annul_i      E-stage flush; cancels the operation, priority over start_i
//   div_stall_o  execute-stage divide stall to the hazard unit
//   ready_o      one-cycle pulse, result_o valid for the HI/LO write
//   result_o     {remainder, quotient}, held until the next completed divide
`timescale 1ns/1ps
module div_iter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic               div_stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StZero, StRun, StDone} stateT;

  stateT            stateQ;
  logic [CNT_W-1:0] cntQ;
  logic [WIDTH-1:0] remQ;     // restored partial remainder, always < divisor
  logic [WIDTH-1:0] quoQ;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] divQ;     // divisor magnitude
  logic             quoNeg;
  logic             remNeg;

  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH:0]   shifted;  // WIDTH+1-bit partial remainder for the trial subtract
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic [WIDTH-1:0] finalQuo;
  logic [WIDTH-1:0] finalRem;
  logic             lastStep;

  always_comb begin
    // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
    dividendMag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    divisorMag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    shifted  = {remQ, quoQ[WIDTH-1]};
    fits     = (shifted >= {1'b0, divQ});
    // When the trial fits the difference is below the divisor, so WIDTH bits suffice.
    diff     = shifted[WIDTH-1:0] - divQ;
    stepRem  = fits ? diff : shifted[WIDTH-1:0];
    stepQuo  = {quoQ[WIDTH-2:0], fits};
    lastStep = (cntQ == CNT_W'(WIDTH - 1));

    finalQuo = quoNeg ? -stepQuo : stepQuo;
    finalRem = remNeg ? -stepRem : stepRem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      divQ     <= '0;
      quoNeg   <= 1'b0;
      remNeg   <= 1'b0;
      result_o <= '0;
    end else if (annul_i) begin
      stateQ <= StIdle;
    end else begin
      case (stateQ)
        StIdle: begin
          if (start_i) begin
            quoQ   <= dividendMag;
            divQ   <= divisorMag;
            remQ   <= '0;
            cntQ   <= '0;
            quoNeg <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            remNeg <= signed_i & dividend_i[WIDTH-1];
            stateQ <= (divisor_i == '0) ? StZero : StRun;
          end
        end
        StZero: begin
          // Divide by zero is architecturally undefined; report zero for determinism.
          result_o <= '0;
          stateQ   <= StDone;
        end
        StRun: begin
          remQ <= stepRem;
          quoQ <= stepQuo;
          cntQ <= cntQ + CNT_W'(1);
          if (lastStep) begin
            result_o <= {finalRem, finalQuo};
            stateQ   <= StDone;
          end
        end
        StDone: begin
          stateQ <= StIdle;
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

  // Stall drops in DONE so the divide instruction advances on the DONE edge.
  assign div_stall_o = ~rst & ~annul_i &
                       (((stateQ == StIdle) & start_i) | (stateQ == StZero) | (stateQ == StRun));
  assign ready_o     = ~rst & ~annul_i & (stateQ == StDone);

endmodule
